mem_arbiter: RTL

- Shares one single-port word memory between the instruction-fetch port (imem) and the load/store port (dmem) of the rv32i pipeline.
- The memory has a 1-cycle registered read, a request strobe, a write-enable (we_re=1 write, 0 read) and a 4-bit byte-lane mask.
- The arbiter grants at most one access per cycle, routes each response back to its owner one cycle later, and prevents fetch starvation.
- Sits between the pipeline front-end/MEM stage and the memory instance.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between the instruction-fetch
// port (imem) and the load/store port (dmem). It grants at most one access per
// cycle and gives dmem priority. A starvation guard forces a fetch through after
// STARVE_LIMIT consecutive dmem grants. Each response returns to its owner exactly
// one cycle after the grant.
module mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              imem_req_valid,
  output logic              imem_req_ready,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rsp_valid,
  output logic [31:0]       imem_rsp_data,

  input  logic              dmem_req_valid,
  output logic              dmem_req_ready,
  input  logic              dmem_we_re,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_wdata,
  input  logic [3:0]        dmem_mask,
  output logic              dmem_rsp_valid,
  output logic [31:0]       dmem_rsp_data,

  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_data_out
);

  // The streak counter only has to count up to STARVE_LIMIT. It keeps one bit
  // even when the guard is disabled.
  localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_e;

  owner_e              rsp_owner, rsp_owner_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic                force_imem;
  logic                grant_i, grant_d;

  // Grant decision: dmem wins unless the fetch side has waited STARVE_LIMIT grants.
  always_comb begin
    force_imem = (STARVE_LIMIT != 0) && (streak == LIMIT);
    grant_d    = !rst && dmem_req_valid && !(imem_req_valid && force_imem);
    grant_i    = !rst && imem_req_valid && !grant_d;
  end

  assign dmem_req_ready = grant_d;
  assign imem_req_ready = grant_i;

  // Memory request mux: drive the granted port's payload, or all zeros when idle.
  always_comb begin
    // NOTE: every output gets a default before the branches so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    mem_request = 1'b0;
    mem_we_re   = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    mem_mask    = 4'b0000;
    if (grant_d) begin
      mem_request = 1'b1;
      mem_we_re   = dmem_we_re;
      mem_address = dmem_addr;
      mem_data_in = dmem_wdata;
      mem_mask    = dmem_mask;
    end else if (grant_i) begin
      mem_request = 1'b1;
      mem_address = imem_addr;
    end
  end

  // Next-state logic for the response owner and the fetch-starvation streak.
  always_comb begin
    rsp_owner_nxt = OWN_NONE;
    streak_nxt    = streak;
    if (grant_d) begin
      rsp_owner_nxt = OWN_DMEM;
    end else if (grant_i) begin
      rsp_owner_nxt = OWN_IMEM;
    end
    // The streak only counts dmem grants taken while a fetch is waiting.
    if (!imem_req_valid || grant_i) begin
      streak_nxt = '0;
    end else if (grant_d && (streak != LIMIT)) begin
      streak_nxt = streak + 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value, whatever order the simulator evaluates blocks in.
    if (rst) begin
      rsp_owner <= OWN_NONE;
      streak    <= '0;
    end else begin
      rsp_owner <= rsp_owner_nxt;
      streak    <= streak_nxt;
    end
  end

  // Response routing: the registered read data goes to whichever port was granted
  // last cycle. A response in flight while reset is high is dropped.
  assign imem_rsp_valid = !rst && (rsp_owner == OWN_IMEM);
  assign dmem_rsp_valid = !rst && (rsp_owner == OWN_DMEM);
  assign imem_rsp_data  = mem_data_out;
  assign dmem_rsp_data  = mem_data_out;

endmodule
